// File: rtl/seq_player_if.sv
// seq_player_if
//   Groups the playback request and LED/status outputs of seq_player.
//   Parameter N must match the N of the seq_player instance it connects to.
//
//   Optional feature macro: SEQ_PLAYER_ABORT_EN (adds the abort request line).
//
//   Signals
//     start   request playback (sampled only while the player is idle)
//     seq     N-bit sequence, step k = seq[N-1-4k -: 4]
//     round   last step index to play
//     abort   cancel a running playback (only with SEQ_PLAYER_ABORT_EN)
//     led_o   nibble being shown, 0 otherwise
//     idx_o   index of the step being played
//     busy_o  playback in progress
//     done_o  one-cycle pulse at the end of a complete playback
//
//   Modports
//     master  requester side (game FSM / testbench)
//     slave   player side (seq_player)
interface seq_player_if #(
  parameter int N = 64
) ();
  logic         start;
  logic [N-1:0] seq;
  logic [3:0]   round;
`ifdef SEQ_PLAYER_ABORT_EN
  logic         abort;
`endif
  logic [3:0]   led_o;
  logic [3:0]   idx_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start,
    output seq,
    output round,
`ifdef SEQ_PLAYER_ABORT_EN
    output abort,
`endif
    input  led_o,
    input  idx_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start,
    input  seq,
    input  round,
`ifdef SEQ_PLAYER_ABORT_EN
    input  abort,
`endif
    output led_o,
    output idx_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/seq_player.sv
// seq_player
//   Plays the round sequence built by the sequence register onto the LEDs,
//   one 4-bit nibble per step, MSB nibble first. Each nibble is shown for
//   ON_CYC cycles followed by an OFF_CYC dark gap. done_o pulses once when
//   the last step's gap has elapsed so the game FSM can open player input.
//
//   Optional feature macro: SEQ_PLAYER_ABORT_EN (abort request on bus.abort).
//
//   Parameters
//     N        sequence width (multiple of 4)
//     ON_CYC   cycles each nibble is shown (>=1)
//     OFF_CYC  cycles of dark gap after each nibble (>=1)
//     CW       timing counter width (must hold max(ON_CYC, OFF_CYC))
//
//   Ports
//     CLK      clock, rising edge
//     R        asynchronous active-low reset
//     bus      seq_player_if.slave (start/seq/round[/abort] in,
//              led_o/idx_o/busy_o/done_o out, all outputs registered)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; outputs dark, not busy
//   SHOW  | nibble idx driven on led_o, counter runs ON_CYC cycles
//   GAP   | led_o dark, counter runs OFF_CYC cycles, then next or FIN
//   FIN   | done_o high for one cycle, busy_o low, then IDLE
module seq_player #(
  parameter int N       = 64,
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 2,
  parameter int CW      = 16
) (
  input  logic          CLK,
  input  logic          R,
  seq_player_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Highest step the sequence can hold; idx is 4 bits so it caps at 15.
  localparam int             LAST_STEP = (N / 4 > 16) ? 15 : (N / 4 - 1);
  localparam logic [3:0]     LAST_IDX  = 4'(LAST_STEP);
  localparam logic [CW-1:0]  ON_LD     = CW'(ON_CYC - 1);
  localparam logic [CW-1:0]  OFF_LD    = CW'(OFF_CYC - 1);

  state_t          state;
  logic [N-1:0]    seq_l;
  logic [3:0]      round_l;
  logic [3:0]      idx;
  logic [CW-1:0]   cnt;
  logic [3:0]      led;
  logic            busy;
  logic            done;
  logic            abort_req;

`ifdef SEQ_PLAYER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // seq_l is kept pre-shifted so the next nibble to show is always its top
  // nibble; this avoids a variable-index mux across the whole sequence.
  // cnt is a down-counter loaded with (length-1); the phase ends when it
  // reaches zero.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state   <= IDLE;
      seq_l   <= '0;
      round_l <= '0;
      idx     <= '0;
      cnt     <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state   <= SHOW;
            led     <= bus.seq[N-1 -: 4];
            seq_l   <= bus.seq << 4;
            round_l <= (bus.round > LAST_IDX) ? LAST_IDX : bus.round;
            idx     <= '0;
            cnt     <= ON_LD;
            busy    <= 1'b1;
          end
        end

        SHOW: begin
          if (abort_req) begin
            state <= IDLE;
            led   <= '0;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (cnt == '0) begin
            state <= GAP;
            led   <= '0;
            cnt   <= OFF_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        GAP: begin
          if (abort_req) begin
            state <= IDLE;
            led   <= '0;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (cnt == '0) begin
            if (idx == round_l) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= SHOW;
              idx   <= idx + 1'b1;
              led   <= seq_l[N-1 -: 4];
              seq_l <= seq_l << 4;
              cnt   <= ON_LD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          led   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led_o  = led;
  assign bus.idx_o  = idx;
  assign bus.busy_o = busy;
  assign bus.done_o = done;

endmodule
